double_to_long: RTL

//  Converts an IEEE-754 double, normally the output of the double_trunc stage, to a signed
//  64-bit integer. The conversion rounds toward zero and saturates out-of-range values.
//  It is an iterative, multi-cycle converter with stb/ack handshakes on both sides.
//  It sits directly downstream of double_trunc in the float-to-integer conversion path.

---
 rtl/double_to_long.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/double_to_long.sv
// IEEE-754 double to signed 64-bit integer, round toward zero with saturation.
// Iterative converter: one operand in flight, stb/ack handshakes on both sides.
module double_to_long #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_a,
  input  logic        in_a_stb,
  output logic        in_a_ack,
  output logic [63:0] out_z,
  output logic        out_z_stb,
  input  logic        out_z_ack,
  output logic        out_ovf
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, PACK, OUT} state_t;

  localparam logic [6:0]  SPC     = SHIFT_PER_CYCLE[6:0];
  localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] mag_q, mag_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic        ovf_q, ovf_d;
  logic [63:0] out_z_q, out_z_d;
  logic        out_z_stb_q, out_z_stb_d;
  logic        out_ovf_q, out_ovf_d;
  logic        in_a_ack_q, in_a_ack_d;

  logic [10:0] exp;
  logic [51:0] frac;
  logic [10:0] cnt_full;
  logic [6:0]  amt;
  logic [6:0]  cnt_left;

  assign exp      = a_q[62:52];
  assign frac     = a_q[51:0];
  assign cnt_full = 11'd1086 - exp;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    special_d   = special_q;
    ovf_d       = ovf_q;
    out_z_d     = out_z_q;
    out_ovf_d   = out_ovf_q;
    amt         = (cnt_q < SPC) ? cnt_q : SPC;
    cnt_left    = cnt_q - amt;
    case (state_q)
      IDLE: begin
        if (in_a_stb && in_a_ack_q) begin
          a_d     = in_a;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d    = a_q[63];
        special_d = 1'b1;
        ovf_d     = 1'b0;
        mag_d     = '0;
        cnt_d     = '0;
        state_d   = PACK;
        if (exp < 11'd1023) begin
          mag_d = '0;
        end else if (exp == 11'd2047) begin
          ovf_d = 1'b1;
          mag_d = (frac != '0 || a_q[63]) ? INT_MIN : INT_MAX;
        end else if (exp >= 11'd1086) begin
          // -2^63 is the one value at this exponent that is representable
          if (a_q[63] && exp == 11'd1086 && frac == '0) begin
            mag_d = INT_MIN;
          end else begin
            ovf_d = 1'b1;
            mag_d = a_q[63] ? INT_MIN : INT_MAX;
          end
        end else begin
          special_d = 1'b0;
          mag_d     = {1'b1, frac, 11'b0};
          cnt_d     = cnt_full[6:0];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        mag_d = mag_q >> amt;
        cnt_d = cnt_left;
        if (cnt_left == '0) state_d = PACK;
      end
      PACK: begin
        out_z_d   = (special_q || !sign_q) ? mag_q : -mag_q;
        out_ovf_d = ovf_q;
        state_d   = OUT;
      end
      OUT: begin
        if (out_z_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_a_ack_d  = (state_d == IDLE);
    out_z_stb_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_z_q     <= '0;
      out_z_stb_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      in_a_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      special_q   <= special_d;
      ovf_q       <= ovf_d;
      out_z_q     <= out_z_d;
      out_z_stb_q <= out_z_stb_d;
      out_ovf_q   <= out_ovf_d;
      in_a_ack_q  <= in_a_ack_d;
    end
  end

  assign in_a_ack  = in_a_ack_q;
  assign out_z     = out_z_q;
  assign out_z_stb = out_z_stb_q;
  assign out_ovf   = out_ovf_q;

endmodule
